mc_controller_hs: RTL and testbench

- Parametrised successor to the team's fixed-latency multicycle controller FSM.
- Drives the same datapath select/enable strobes.
- Adds a memory request/ready handshake with a wait-state timeout watchdog, a sticky fault state with cause code, and a retired-instruction counter.
- Sits between the instruction register decode fields and the datapath/memory interface.

---
 rtl/mc_ctrl_pkg.sv | 103 ++++++++++
 rtl/mc_cond_eval.sv | 40 ++++
 rtl/mc_controller_hs.sv | 152 +++++++++++++++
 tb/tb_mc_controller_hs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the handshaked multicycle
// controller (mc_controller_hs) and its condition evaluator (mc_cond_eval).
// Holds the 5-bit state encoding, opcode/op_ext/condition constants, PSR
// bit indices, fault cause codes, the strobe bundle and its Moore decoder.
// Optional feature macro: MC_CTRL_SINGLE_STEP_EN (adds the IDLE state).
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    FETCH_REQ  = 5'd0,
    FETCH_WAIT = 5'd1,
    DECODE     = 5'd2,
    RTYPE_EX   = 5'd3,
    ITYPE_EX   = 5'd4,
    WRITE      = 5'd5,
    LD_REQ     = 5'd6,
    LD_WAIT    = 5'd7,
    LD_WB      = 5'd8,
    ST_REQ     = 5'd9,
    ST_WAIT    = 5'd10,
    B_DISP     = 5'd11,
    JUMP       = 5'd12,
    LINK_CALC  = 5'd13,
    LINK_WR    = 5'd14,
    PC_UP      = 5'd15,
`ifdef MC_CTRL_SINGLE_STEP_EN
    IDLE       = 5'd17,
`endif
    FAULT      = 5'd16
  } state_t;

  // Primary opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  // Extended opcodes
  localparam logic [3:0] OPX_LOAD  = 4'b0000;
  localparam logic [3:0] OPX_STOR  = 4'b0100;
  localparam logic [3:0] OPX_JAL   = 4'b1000;
  localparam logic [3:0] OPX_CMP   = 4'b1011;
  localparam logic [3:0] OPX_JCOND = 4'b1100;
  // Condition codes
  localparam logic [3:0] CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010,
                         CC_CC = 4'b0011, CC_HI = 4'b0100, CC_LS = 4'b0101,
                         CC_GT = 4'b0110, CC_LE = 4'b0111, CC_FS = 4'b1000,
                         CC_FC = 4'b1001, CC_LO = 4'b1010, CC_HS = 4'b1011,
                         CC_LT = 4'b1100, CC_GE = 4'b1101, CC_UC = 4'b1110;
  // PSR bit indices
  localparam int PSR_C = 0, PSR_L = 1, PSR_F = 2, PSR_Z = 3, PSR_N = 4;
  // Fault causes
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // instr_gate / ld_gate are qualified by mem_ready at the top level.
  typedef struct packed {
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [1:0] alub_s;
    logic       pc_s;
    logic       pc_en;
    logic       reg_wr_en;
    logic       instr_gate;
    logic       alu_out_en;
    logic       ld_gate;
    logic       mem_wr;
    logic       mem_s;
    logic       se_sign;
    logic       psr_en;
    logic       mem_req;
  } strb_t;

  // Zero-extended immediates for the logical I-type ops.
  function automatic logic imm_unsigned(logic [3:0] op);
    return op inside {4'b0001, 4'b0010, 4'b0011, 4'b1101};
  endfunction

  function automatic strb_t decode(state_t s, logic [3:0] op);
    strb_t d;
    d         = '0;
    d.se_sign = 1'b1;
    case (s)
      FETCH_REQ, FETCH_WAIT: begin d.mem_s = 1'b1; d.mem_req = 1'b1; d.instr_gate = 1'b1; end
      RTYPE_EX:  begin d.alu_out_en = 1'b1; d.psr_en = 1'b1; end
      ITYPE_EX:  begin
        d.alua_s = 2'b10; d.alu_out_en = 1'b1; d.psr_en = 1'b1;
        d.se_sign = ~imm_unsigned(op);
      end
      WRITE:     begin d.wd_s = 2'b11; d.reg_wr_en = 1'b1; end
      LD_REQ, LD_WAIT: begin d.mem_req = 1'b1; d.ld_gate = 1'b1; end
      LD_WB:     begin d.wd_s = 2'b10; d.reg_wr_en = 1'b1; end
      ST_REQ, ST_WAIT: begin d.mem_req = 1'b1; d.mem_wr = 1'b1; end
      B_DISP:    begin d.alua_s = 2'b01; d.alub_s = 2'b01; d.pc_s = 1'b1; d.pc_en = 1'b1; end
      JUMP:      d.pc_en = 1'b1;
      LINK_CALC: begin d.alua_s = 2'b01; d.alub_s = 2'b10; d.alu_out_en = 1'b1; end
      LINK_WR:   begin d.wd_s = 2'b11; d.reg_wr_en = 1'b1; d.pc_en = 1'b1; end
      PC_UP:     begin d.alua_s = 2'b01; d.alub_s = 2'b10; d.pc_s = 1'b1; d.pc_en = 1'b1; end
      default:   ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_cond_eval.sv
// mc_cond_eval: combinational branch-condition evaluator (CR16 encoding).
// Ports: branch_cond[3:0], psr[PSR_W-1:0] in; taken out. Code 1111 is never taken.
module mc_cond_eval
  import mc_ctrl_pkg::*;
#(
  parameter int PSR_W = 5
) (
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] psr,
  output logic             taken
);
  logic c, l, f, z, n;
  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  always_comb begin
    taken = 1'b0;
    case (branch_cond)
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_HI: taken = l;
      CC_LS: taken = ~l;
      CC_GT: taken = n;
      CC_LE: taken = ~n;
      CC_FS: taken = f;
      CC_FC: taken = ~f;
      CC_LO: taken = ~z & ~l;
      CC_HS: taken = z | l;
      CC_LT: taken = ~z & ~n;
      CC_GE: taken = z | n;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle controller FSM with memory req/ready
// handshake, wait-state watchdog, sticky fault (with cause) and a
// retired-instruction counter.
// Ports: clk, reset (sync, active high); op, op_ext, branch_cond, psr,
//   mem_ready in; mem_req, datapath selects/strobes, fault, fault_code,
//   retired out. With MC_CTRL_SINGLE_STEP_EN defined, run/step inputs gate
//   instruction issue through an IDLE state.
// Strobes are registered from the next state, so they are a pure function
// of the current state; instr_en/mem_reg_en are additionally qualified by
// mem_ready. Reset lands in FETCH_REQ, so the first fetch request is up
// in the cycle after reset.
module mc_controller_hs
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 16,
  parameter int PSR_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [3:0]       op_ext,
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] psr,
`ifdef MC_CTRL_SINGLE_STEP_EN
  input  logic             run,
  input  logic             step,
`endif
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       wd_s,
  output logic [1:0]       alua_s,
  output logic [1:0]       alub_s,
  output logic             pc_s,
  output logic             pc_en,
  output logic             reg_wr_en,
  output logic             instr_en,
  output logic             alu_out_en,
  output logic             mem_reg_en,
  output logic             mem_wr,
  output logic             mem_s,
  output logic             se_sign,
  output logic             psr_en,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [RET_W-1:0] retired
);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit WD_ON = (MEM_TIMEOUT > 0);
`ifdef MC_CTRL_SINGLE_STEP_EN
  localparam state_t RST_ST = IDLE;
`else
  localparam state_t RST_ST = FETCH_REQ;
`endif

  state_t        state, state_nxt, done_nxt;
  strb_t         strb;
  logic [CW-1:0] wd_cnt;
  logic          taken, is_wait, wd_fire;

  mc_cond_eval #(.PSR_W(PSR_W)) u_cond (
    .branch_cond (branch_cond),
    .psr         (psr),
    .taken       (taken)
  );

  assign is_wait = (state == FETCH_WAIT) || (state == LD_WAIT) || (state == ST_WAIT);
  // A ready in the limit cycle wins over the timeout.
  assign wd_fire = WD_ON && is_wait && !mem_ready && (wd_cnt == WD_LAST);

`ifdef MC_CTRL_SINGLE_STEP_EN
  assign done_nxt = (run || step) ? FETCH_REQ : IDLE;
`else
  assign done_nxt = FETCH_REQ;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_REQ, FETCH_WAIT: state_nxt = mem_ready ? DECODE : (wd_fire ? FAULT : FETCH_WAIT);
      DECODE: begin
        case (op)
          OP_RTYPE: state_nxt = RTYPE_EX;
          OP_BCOND: state_nxt = taken ? B_DISP : PC_UP;
          OP_MEM: begin
            case (op_ext)
              OPX_LOAD:  state_nxt = LD_REQ;
              OPX_STOR:  state_nxt = ST_REQ;
              OPX_JCOND: state_nxt = taken ? JUMP : PC_UP;
              OPX_JAL:   state_nxt = LINK_CALC;
              default:   state_nxt = FAULT;
            endcase
          end
          default: state_nxt = ITYPE_EX;
        endcase
      end
      RTYPE_EX:        state_nxt = (op_ext == OPX_CMP) ? PC_UP : WRITE;
      ITYPE_EX:        state_nxt = (op == OP_CMPI) ? PC_UP : WRITE;
      WRITE, LD_WB:    state_nxt = PC_UP;
      LD_REQ, LD_WAIT: state_nxt = mem_ready ? LD_WB : (wd_fire ? FAULT : LD_WAIT);
      ST_REQ, ST_WAIT: state_nxt = mem_ready ? PC_UP : (wd_fire ? FAULT : ST_WAIT);
      LINK_CALC:       state_nxt = LINK_WR;
      B_DISP, JUMP, LINK_WR, PC_UP: state_nxt = done_nxt;
`ifdef MC_CTRL_SINGLE_STEP_EN
      IDLE:            state_nxt = done_nxt;
`endif
      FAULT:           state_nxt = FAULT;
      default:         state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_ST;
      strb       <= decode(RST_ST, op);
      wd_cnt     <= '0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      retired    <= '0;
    end else begin
      state <= state_nxt;
      strb  <= decode(state_nxt, op);
      fault <= (state_nxt == FAULT);
      // Only the first cause is recorded; FAULT is absorbing.
      if (state_nxt == FAULT && state != FAULT)
        fault_code <= (state == DECODE) ? FLT_ILLEGAL : FLT_TIMEOUT;
      if (state == PC_UP || state == B_DISP || state == JUMP || state == LINK_WR)
        retired <= retired + RET_W'(1);
      // *_REQ states last one cycle, so entering one restarts the watchdog.
      if (state_nxt == FETCH_REQ || state_nxt == LD_REQ || state_nxt == ST_REQ)
        wd_cnt <= '0;
      else if (WD_ON && is_wait && !mem_ready && !wd_fire)
        wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign mem_req    = strb.mem_req;
  assign wd_s       = strb.wd_s;
  assign alua_s     = strb.alua_s;
  assign alub_s     = strb.alub_s;
  assign pc_s       = strb.pc_s;
  assign pc_en      = strb.pc_en;
  assign reg_wr_en  = strb.reg_wr_en;
  assign instr_en   = strb.instr_gate & mem_ready;
  assign alu_out_en = strb.alu_out_en;
  assign mem_reg_en = strb.ld_gate & mem_ready;
  assign mem_wr     = strb.mem_wr;
  assign mem_s      = strb.mem_s;
  assign se_sign    = strb.se_sign;
  assign psr_en     = strb.psr_en;
endmodule

// File: tb/tb_mc_controller_hs.sv
// tb_mc_controller_hs: directed self-checking bench for mc_controller_hs
// (MEM_TIMEOUT=4). Inputs change 1 ns after the rising edge; outputs are
// checked there too, well away from the next edge.
module tb_mc_controller_hs;
  import mc_ctrl_pkg::*;
  localparam int RET_W = 16;
  localparam int PSR_W = 5;
`ifdef MC_CTRL_SINGLE_STEP_EN
  localparam state_t RST_ST = IDLE;
`else
  localparam state_t RST_ST = FETCH_REQ;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [3:0] op, op_ext, branch_cond;
  logic [PSR_W-1:0] psr;
  logic mem_ready, mem_req;
  logic [1:0] wd_s, alua_s, alub_s, fault_code;
  logic pc_s, pc_en, reg_wr_en, instr_en, alu_out_en, mem_reg_en;
  logic mem_wr, mem_s, se_sign, psr_en, fault;
  logic [RET_W-1:0] retired;
`ifdef MC_CTRL_SINGLE_STEP_EN
  logic run, step;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_controller_hs #(.MEM_TIMEOUT(4), .RET_W(RET_W), .PSR_W(PSR_W)) dut (
    .clk(clk), .reset(reset), .op(op), .op_ext(op_ext),
    .branch_cond(branch_cond), .psr(psr),
`ifdef MC_CTRL_SINGLE_STEP_EN
    .run(run), .step(step),
`endif
    .mem_ready(mem_ready), .mem_req(mem_req), .wd_s(wd_s), .alua_s(alua_s),
    .alub_s(alub_s), .pc_s(pc_s), .pc_en(pc_en), .reg_wr_en(reg_wr_en),
    .instr_en(instr_en), .alu_out_en(alu_out_en), .mem_reg_en(mem_reg_en),
    .mem_wr(mem_wr), .mem_s(mem_s), .se_sign(se_sign), .psr_en(psr_en),
    .fault(fault), .fault_code(fault_code), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    chk_st({tag, "_state"}, RST_ST);
    chk({tag, "_mem_req"}, mem_req, (RST_ST == FETCH_REQ) ? 1 : 0);
    chk({tag, "_pc_en"}, pc_en, 0);
    chk({tag, "_se_sign"}, se_sign, 1);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_fault_code"}, fault_code, 0);
    chk({tag, "_retired"}, retired, 0);
    reset = 1'b0;
  endtask

  // With single-step built in, leave IDLE (run is high) for the main tests.
  task automatic start();
`ifdef MC_CTRL_SINGLE_STEP_EN
    tick();
    chk_st("start_fetch", FETCH_REQ);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op = 4'h0; op_ext = 4'h0; branch_cond = 4'h0; psr = '0;
    mem_ready = 1'b0;
`ifdef MC_CTRL_SINGLE_STEP_EN
    run = 1'b1; step = 1'b0;
`endif
    do_reset("rst");
    start();

    // ADD, ready tied high
    op = OP_RTYPE; op_ext = 4'b0101; mem_ready = 1'b1; #1;
    chk("add_instr_en", instr_en, 1);
    tick(); chk_st("add_decode", DECODE);
    tick(); chk_st("add_rtype", RTYPE_EX); chk("add_alu_out_en", alu_out_en, 1); chk("add_psr_en", psr_en, 1);
    tick(); chk_st("add_write", WRITE); chk("add_reg_wr", reg_wr_en, 1); chk("add_wd_s", wd_s, 3);
    tick(); chk_st("add_pcup", PC_UP); chk("add_reg_wr_off", reg_wr_en, 0); chk("add_pc_en", pc_en, 1);
    chk("add_pc_s", pc_s, 1); chk("add_ret_before", retired, 0);
    tick(); chk_st("add_fetch", FETCH_REQ); chk("add_retired", retired, 1);

    // Load, ready after three wait cycles
    op = OP_MEM; op_ext = OPX_LOAD;
    tick(); chk_st("ld_decode", DECODE); mem_ready = 1'b0;
    tick(); chk_st("ld_req", LD_REQ); chk("ld_req_mem_req", mem_req, 1); chk("ld_req_mem_reg_en", mem_reg_en, 0);
    tick(); chk_st("ld_wait1", LD_WAIT);
    tick(); chk("ld_wait2_mem_req", mem_req, 1);
    tick(); chk_st("ld_wait3", LD_WAIT); mem_ready = 1'b1; #1;
    chk("ld_mem_reg_en", mem_reg_en, 1); chk("ld_wait3_mem_req", mem_req, 1);
    tick(); chk_st("ld_wb", LD_WB); chk("ld_wb_wd_s", wd_s, 2); chk("ld_wb_reg_wr", reg_wr_en, 1);
    chk("ld_wb_mem_req", mem_req, 0);
    tick(); chk_st("ld_pcup", PC_UP);
    tick(); chk("ld_retired", retired, 2);

    // Bcond EQ taken (Z=1) and not taken (Z=0)
    op = OP_BCOND; branch_cond = CC_EQ; psr = 5'b01000;
    tick(); tick(); chk_st("beq_t_state", B_DISP); chk("beq_t_pc_en", pc_en, 1); chk("beq_t_pc_s", pc_s, 1);
    chk("beq_t_alub_s", alub_s, 1);
    tick(); chk("beq_t_retired", retired, 3);
    psr = 5'b00000;
    tick(); tick(); chk_st("beq_nt_state", PC_UP);
    tick(); chk("beq_nt_retired", retired, 4);
    // LT with Z=0, N=0 is taken; GE with the same flags is not
    branch_cond = CC_LT;
    tick(); tick(); chk_st("blt_t_state", B_DISP);
    tick();
    branch_cond = CC_GE;
    tick(); tick(); chk_st("bge_nt_state", PC_UP);
    tick(); chk("bcc_retired", retired, 6);

    // I-type with zero-extended immediate, then CMPI (no writeback)
    op = 4'b0001;
    tick(); tick(); chk_st("itype_state", ITYPE_EX); chk("itype_se_sign", se_sign, 0); chk("itype_alua", alua_s, 2);
    tick(); chk_st("itype_write", WRITE);
    tick(); tick(); chk("itype_retired", retired, 7);
    op = OP_CMPI;
    tick(); tick(); chk("cmpi_se_sign", se_sign, 1);
    tick(); chk_st("cmpi_pcup", PC_UP);
    tick();

    // Jcond UC, JAL, store
    op = OP_MEM; op_ext = OPX_JCOND; branch_cond = CC_UC;
    tick(); tick(); chk_st("jump_state", JUMP); chk("jump_pc_en", pc_en, 1); chk("jump_pc_s", pc_s, 0);
    tick(); chk("jump_retired", retired, 9);
    op_ext = OPX_JAL;
    tick(); tick(); chk_st("jal_calc", LINK_CALC); chk("jal_alub", alub_s, 2); chk("jal_alu_out_en", alu_out_en, 1);
    tick(); chk_st("jal_wr", LINK_WR); chk("jal_reg_wr", reg_wr_en, 1); chk("jal_pc_en", pc_en, 1);
    tick(); chk("jal_retired", retired, 10);
    op_ext = OPX_STOR;
    tick(); tick(); chk_st("st_req", ST_REQ); chk("st_mem_wr", mem_wr, 1); chk("st_mem_req", mem_req, 1);
    tick(); chk_st("st_pcup", PC_UP); chk("st_mem_wr_off", mem_wr, 0);
    tick(); chk("st_retired", retired, 11);

    // Illegal op_ext
    op_ext = 4'b1111;
    tick(); tick(); chk_st("ill_state", FAULT); chk("ill_fault", fault, 1); chk("ill_code", fault_code, 1);
    chk("ill_mem_req", mem_req, 0);
    tick(); tick(); chk("ill_hold_fault", fault, 1); chk("ill_hold_code", fault_code, 1);
    do_reset("rst_ill");
    start();

    // Fetch timeout: fault after the fourth ready-less wait cycle
    mem_ready = 1'b0; op = OP_RTYPE;
    tick(); chk_st("to_wait1", FETCH_WAIT);
    tick(); tick(); tick(); chk_st("to_wait4", FETCH_WAIT); chk("to_wait4_fault", fault, 0);
    tick(); chk_st("to_state", FAULT); chk("to_fault", fault, 1); chk("to_code", fault_code, 2);
    chk("to_mem_req", mem_req, 0);
    mem_ready = 1'b1;
    tick(); chk_st("to_hold", FAULT); chk("to_hold_code", fault_code, 2);
    do_reset("rst_to");
    start();

    // Ready in the limit cycle wins
    mem_ready = 1'b0;
    tick(); tick(); tick(); tick(); chk_st("lim_wait4", FETCH_WAIT);
    mem_ready = 1'b1; op = OP_MEM; op_ext = OPX_LOAD;
    tick(); chk_st("lim_decode", DECODE); chk("lim_fault", fault, 0);
    // Reset in the middle of a load wait
    mem_ready = 1'b0;
    tick(); tick(); chk_st("mid_ld_wait", LD_WAIT);
    do_reset("rst_mid");

`ifdef MC_CTRL_SINGLE_STEP_EN
    // One step pulse admits exactly one instruction
    run = 1'b0; op = OP_RTYPE; op_ext = 4'b0101; mem_ready = 1'b1;
    tick(); chk_st("ss_idle", IDLE);
    step = 1'b1;
    tick(); chk_st("ss_fetch", FETCH_REQ); step = 1'b0;
    tick(); tick(); tick(); tick(); chk_st("ss_pcup", PC_UP);
    tick(); chk_st("ss_back_idle", IDLE); chk("ss_retired", retired, 1);
    tick(); chk_st("ss_stay_idle", IDLE); chk("ss_retired_hold", retired, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
